b2onehot_pipe: RTL and testbench
================================

Name: b2onehot_pipe

Overview:
- Parametrised, registered successor to the combinational 4-to-16 binary-to-one-hot decoder.
- Decodes an IN_W-bit binary index into an OUT_W-bit one-hot or thermometer code, selected per beat.
- Valid/ready handshake on both sides, backed by a 2-entry skid buffer, so it drops into streaming datapaths without combinational ready paths.
- Flags out-of-range indices per beat and counts them in a saturating error counter.

Parameters:
- IN_W, 4, width of the binary index input.
- OUT_W, 16, width of the decoded output. Legal range 2..2^IN_W; elaboration fails outside this range.
- ERR_CNT_W, 8, width of the saturating out-of-range counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept a beat. Driven directly from a flop.
- in_bin  input  IN_W  binary index.
- in_mode  input  1  0 = one-hot, 1 = thermometer.
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accepts the beat.
- out_code  output  OUT_W  decoded code.
- out_err  output  1  the beat's index was >= OUT_W.
- err_clr  input  1  synchronous clear of err_cnt.
- err_cnt  output  ERR_CNT_W  saturating count of out-of-range beats accepted.

Behaviour:
- Reset (async assert, sync release) drives:
  - out_valid=0, out_code=0, out_err=0, err_cnt=0.
  - Skid buffer empty.
  - in_ready=1 from the first clock after rst_n deasserts.
- Transfers:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - out_code and out_err hold stable while out_valid && !out_ready.
- Decode, computed at input acceptance on in_bin = k:
  - One-hot: bit k set, all others 0.
  - Thermometer: bits k..0 set, bits above k clear.
  - k >= OUT_W: out_code = all zeros in either mode, out_err=1. Otherwise out_err=0.
- Storage: output register (OR) plus skid register (SR).
  - in_ready = !SR_full, registered.
- Datapath rules:
  - Accept while OR empty, or OR transferring this cycle with SR empty: decoded beat goes to OR.
  - Accept while OR full and not transferring: decoded beat goes to SR.
  - OR transferring while SR full: SR moves to OR, SR empties, in_ready returns to 1 next cycle.
  - SR full: no input accepted. in_valid is ignored and holding in_bin and in_mode stable is the source's responsibility.
- Latency and throughput:
  - Latency is 1 cycle: a beat accepted at edge N is on out_code after edge N.
  - Full throughput of 1 beat/cycle while out_ready stays high.
  - Beat order is always preserved.
- Buffer state machine: EMPTY -> ONE (OR full) -> TWO (OR+SR full) -> back on output transfers.
  - Simultaneous accept and transfer in ONE stays in ONE.
  - TWO never accepts input.
- Error counter:
  - Increments on every input transfer with k >= OUT_W.
  - Saturates at 2^ERR_CNT_W-1 with no wrap.
  - err_clr zeroes the counter. If err_clr and an out-of-range accept occur in the same cycle, err_cnt = 1.
- Mode: in_mode is sampled only at acceptance. Changing it mid-stall does not alter buffered beats.
- Reset mid-operation: rst_n assertion discards all buffered beats immediately, and all outputs return to their reset values asynchronously.
- OUT_W = 2^IN_W: out_err can never assert, and the range comparison may be optimised away.

Test Plan:
- Defaults, one-hot, out_ready=1, stream in_bin = 0, 1, 2, 4, 8, 15 -> out_code = 0x0001, 0x0002, 0x0004, 0x0010, 0x0100, 0x8000 on consecutive cycles; latency 1; err_cnt = 0.
- Thermometer, in_bin = 0, 3, 15 -> out_code = 0x0001, 0x000F, 0xFFFF.
- OUT_W=10, in_bin = 9, 10, 15 in one-hot -> out_code = 0x200 with out_err=0, then 0x000 with out_err=1, then 0x000 with out_err=1; err_cnt = 2.
- Backpressure: hold out_ready=0, offer 3 beats (5, 6, 7):
  - Two are accepted, then in_ready=0 with beat 7 held.
  - Release out_ready: outputs 0x0020, 0x0040, 0x0080 in order with nothing lost or duplicated.
  - Randomised valid/ready soak compared against a reference queue.
- ERR_CNT_W=2, send 5 out-of-range beats -> err_cnt saturates at 3.
  - err_clr together with an out-of-range accept -> err_cnt = 1.
- Two beats buffered, assert rst_n=0 mid-cycle -> out_valid = 0 immediately and err_cnt = 0.
  - After release, first accepted beat in_bin=2 -> 0x0004; no stale beats appear.

Source files
------------

// File: rtl/b2onehot_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : b2onehot_pipe
//  Purpose  : Registered binary -> one-hot / thermometer decoder with a
//             valid/ready handshake, a 2-entry skid buffer (output register
//             plus skid register) and a saturating out-of-range counter.
//  Revision : 1.0 - initial release
// ============================================================================
module b2onehot_pipe #(
    parameter int IN_W      = 4,
    parameter int OUT_W     = 16,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_W-1:0]      in_bin,
    input  logic                 in_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_W-1:0]     out_code,
    output logic                 out_err,
    input  logic                 err_clr,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    // Occupancy of the two-entry buffer: EMPTY, OR only, OR and SR.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    localparam logic [ERR_CNT_W-1:0] c_err_max = '1;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_in_ready;
    logic [OUT_W-1:0]       r_or_code;
    logic                   r_or_err;
    logic [OUT_W-1:0]       r_sr_code;
    logic                   r_sr_err;
    logic [ERR_CNT_W-1:0]   r_err_cnt;

    logic                   w_in_fire;
    logic                   w_out_fire;
    logic                   w_out_valid;
    logic                   w_load_or_in;
    logic                   w_load_or_sr;
    logic                   w_load_sr;
    logic [OUT_W-1:0]       w_dec_code;
    logic                   w_dec_err;
    logic                   w_err_inc;

    // Reject widths that cannot be represented by the index.
    if (OUT_W < 2 || OUT_W > (1 << IN_W)) begin : g_bad_out_w
        $error("b2onehot_pipe: OUT_W must lie in 2..2**IN_W");
    end

    // When the output covers every index value no index can be out of range.
    if (OUT_W == (1 << IN_W)) begin : g_range_full
        assign w_dec_err = 1'b0;
    end else begin : g_range_part
        assign w_dec_err = (in_bin >= IN_W'(OUT_W));
    end

    assign w_out_valid = (r_state != S_EMPTY);
    assign w_in_fire   = in_valid && r_in_ready;
    assign w_out_fire  = w_out_valid && out_ready;
    assign w_err_inc   = w_in_fire && w_dec_err;

    assign in_ready  = r_in_ready;
    assign out_valid = w_out_valid;
    assign out_code  = r_or_code;
    assign out_err   = r_or_err;
    assign err_cnt   = r_err_cnt;

    // Decode the offered index; out-of-range indices give an all-zero code.
    always_comb begin
        w_dec_code = '0;
        for (int i = 0; i < OUT_W; i++) begin
            if (in_mode) begin
                w_dec_code[i] = (IN_W'(i) <= in_bin);
            end else begin
                w_dec_code[i] = (IN_W'(i) == in_bin);
            end
        end
        if (w_dec_err) begin
            w_dec_code = '0;
        end
    end

    // Buffer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and load-enable selection for the OR/SR pair.
    always_comb begin
        w_state_nxt  = r_state;
        w_load_or_in = 1'b0;
        w_load_or_sr = 1'b0;
        w_load_sr    = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (w_in_fire) begin
                    w_load_or_in = 1'b1;
                    w_state_nxt  = S_ONE;
                end
            end
            S_ONE: begin
                if (w_in_fire && w_out_fire) begin
                    w_load_or_in = 1'b1;
                end else if (w_in_fire) begin
                    w_load_sr   = 1'b1;
                    w_state_nxt = S_TWO;
                end else if (w_out_fire) begin
                    w_state_nxt = S_EMPTY;
                end
            end
            S_TWO: begin
                if (w_out_fire) begin
                    w_load_or_sr = 1'b1;
                    w_state_nxt  = S_ONE;
                end
            end
            default: begin
                w_state_nxt = S_EMPTY;
            end
        endcase
    end

    // in_ready is a flop: low exactly while the skid register holds a beat.
    // It comes out of reset low and rises on the first clock afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_ready <= 1'b0;
        end else begin
            r_in_ready <= (w_state_nxt != S_TWO);
        end
    end

    // Output register and skid register data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_or_code <= '0;
            r_or_err  <= 1'b0;
            r_sr_code <= '0;
            r_sr_err  <= 1'b0;
        end else begin
            if (w_load_or_in) begin
                r_or_code <= w_dec_code;
                r_or_err  <= w_dec_err;
            end else if (w_load_or_sr) begin
                r_or_code <= r_sr_code;
                r_or_err  <= r_sr_err;
            end
            if (w_load_sr) begin
                r_sr_code <= w_dec_code;
                r_sr_err  <= w_dec_err;
            end
        end
    end

    // Saturating out-of-range counter; a clear still counts a coincident error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if (err_clr) begin
            r_err_cnt <= w_err_inc ? ERR_CNT_W'(1) : '0;
        end else if (w_err_inc && (r_err_cnt != c_err_max)) begin
            r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_b2onehot_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_b2onehot_pipe
//  Purpose  : Directed self-checking bench for b2onehot_pipe. dut_a uses the
//             default parameters, dut_b uses OUT_W=10 and ERR_CNT_W=2.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_b2onehot_pipe;

    logic        clk;
    logic        rst_n;

    logic        a_in_valid, a_in_ready, a_in_mode, a_out_valid, a_out_ready;
    logic [3:0]  a_in_bin;
    logic [15:0] a_out_code;
    logic        a_out_err, a_err_clr;
    logic [7:0]  a_err_cnt;

    logic        b_in_valid, b_in_ready, b_in_mode, b_out_valid, b_out_ready;
    logic [3:0]  b_in_bin;
    logic [9:0]  b_out_code;
    logic        b_out_err, b_err_clr;
    logic [1:0]  b_err_cnt;

    int checks   = 0;
    int failures = 0;

    b2onehot_pipe dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_bin    (a_in_bin),
        .in_mode   (a_in_mode),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_code  (a_out_code),
        .out_err   (a_out_err),
        .err_clr   (a_err_clr),
        .err_cnt   (a_err_cnt)
    );

    b2onehot_pipe #(.IN_W(4), .OUT_W(10), .ERR_CNT_W(2)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_bin    (b_in_bin),
        .in_mode   (b_in_mode),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_code  (b_out_code),
        .out_err   (b_out_err),
        .err_clr   (b_err_clr),
        .err_cnt   (b_err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] ref_code(input logic [3:0] k, input logic mode);
        logic [31:0] one;
        one = 32'h1;
        if (mode) return 16'((one << (k + 1)) - 1);
        return 16'(one << k);
    endfunction

    initial begin : main
        logic [3:0]  vec_bin [6];
        logic [15:0] vec_exp [6];
        logic [3:0]  th_bin  [3];
        logic [15:0] th_exp  [3];
        logic [15:0] q [$];
        logic        pending, in_fire, out_fire;

        vec_bin = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd8, 4'd15};
        vec_exp = '{16'h0001, 16'h0002, 16'h0004, 16'h0010, 16'h0100, 16'h8000};
        th_bin  = '{4'd0, 4'd3, 4'd15};
        th_exp  = '{16'h0001, 16'h000F, 16'hFFFF};

        rst_n = 1'b0;
        a_in_valid = 0; a_in_bin = 0; a_in_mode = 0; a_out_ready = 0; a_err_clr = 0;
        b_in_valid = 0; b_in_bin = 0; b_in_mode = 0; b_out_ready = 0; b_err_clr = 0;

        // ---------------- reset values ----------------
        tick(); tick();
        chk("rst_out_valid", 32'(a_out_valid), 0);
        chk("rst_out_code",  32'(a_out_code),  0);
        chk("rst_out_err",   32'(a_out_err),   0);
        chk("rst_err_cnt",   32'(a_err_cnt),   0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_in_ready", 32'(a_in_ready), 1);
        chk("post_rst_idle",     32'(a_out_valid), 0);

        // ---------------- one-hot stream, full throughput ----------------
        a_out_ready = 1;
        for (int i = 0; i < 6; i++) begin
            a_in_valid = 1; a_in_bin = vec_bin[i]; a_in_mode = 0;
            tick();
            chk("oh_valid", 32'(a_out_valid), 1);
            chk("oh_code",  32'(a_out_code),  32'(vec_exp[i]));
            chk("oh_ready", 32'(a_in_ready),  1);
        end
        a_in_valid = 0;
        tick();
        chk("oh_drain",   32'(a_out_valid), 0);
        chk("oh_err_cnt", 32'(a_err_cnt),   0);

        // ---------------- thermometer ----------------
        for (int i = 0; i < 3; i++) begin
            a_in_valid = 1; a_in_bin = th_bin[i]; a_in_mode = 1;
            tick();
            chk("th_code", 32'(a_out_code), 32'(th_exp[i]));
            chk("th_err",  32'(a_out_err),  0);
        end
        a_in_valid = 0; a_in_mode = 0;
        tick();
        chk("th_drain", 32'(a_out_valid), 0);

        // ---------------- backpressure: 5, 6, 7 with out_ready low ----------------
        a_out_ready = 0;
        a_in_valid = 1; a_in_bin = 4'd5;
        tick();
        chk("bp_first_code", 32'(a_out_code), 32'h0020);
        chk("bp_first_rdy",  32'(a_in_ready), 1);
        a_in_bin = 4'd6;
        tick();
        chk("bp_full_rdy",  32'(a_in_ready), 0);
        chk("bp_hold_code", 32'(a_out_code), 32'h0020);
        a_in_bin = 4'd7;
        tick();
        chk("bp_stall_rdy",  32'(a_in_ready), 0);
        chk("bp_stall_code", 32'(a_out_code), 32'h0020);
        chk("bp_stall_vld",  32'(a_out_valid), 1);
        a_out_ready = 1;
        tick();
        chk("bp_rel_code", 32'(a_out_code), 32'h0040);
        chk("bp_rel_rdy",  32'(a_in_ready), 1);
        tick();
        chk("bp_last_code", 32'(a_out_code), 32'h0080);
        a_in_valid = 0;
        tick();
        chk("bp_empty", 32'(a_out_valid), 0);

        // ---------------- randomised soak against a reference queue ----------------
        pending = 0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            chk("soak_valid", 32'(a_out_valid), 32'(q.size() > 0));
            chk("soak_ready", 32'(a_in_ready),  32'(q.size() < 2));
            if (q.size() > 0) chk("soak_code", 32'(a_out_code), 32'(q[0]));
            if (!pending) begin
                a_in_valid = 1'($urandom_range(0, 1));
                a_in_bin   = 4'($urandom_range(0, 15));
                a_in_mode  = 1'($urandom_range(0, 1));
            end
            a_out_ready = ($urandom_range(0, 3) != 0);
            in_fire  = a_in_valid && a_in_ready;
            out_fire = a_out_valid && a_out_ready;
            pending  = a_in_valid && !in_fire;
            tick();
            if (out_fire) void'(q.pop_front());
            if (in_fire)  q.push_back(ref_code(a_in_bin, a_in_mode));
        end
        a_in_valid = 0; a_out_ready = 1;
        tick(); tick(); tick();
        chk("soak_drained", 32'(a_out_valid), 0);

        // ---------------- OUT_W=10 range checks and saturation ----------------
        b_out_ready = 1; b_in_valid = 1; b_in_mode = 0;
        b_in_bin = 4'd9;
        tick();
        chk("b9_code", 32'(b_out_code), 32'h200);
        chk("b9_err",  32'(b_out_err),  0);
        b_in_bin = 4'd10;
        tick();
        chk("b10_code", 32'(b_out_code), 0);
        chk("b10_err",  32'(b_out_err),  1);
        b_in_bin = 4'd15; b_in_mode = 1;
        tick();
        chk("b15_code", 32'(b_out_code), 0);
        chk("b15_err",  32'(b_out_err),  1);
        chk("b_cnt2",   32'(b_err_cnt),  2);
        b_in_bin = 4'd11; tick();
        b_in_bin = 4'd12; tick();
        chk("b_cnt_sat_a", 32'(b_err_cnt), 3);
        b_in_bin = 4'd13; tick();
        chk("b_cnt_sat_b", 32'(b_err_cnt), 3);
        b_err_clr = 1; b_in_bin = 4'd14;
        tick();
        chk("b_clr_with_err", 32'(b_err_cnt), 1);
        b_err_clr = 0; b_in_valid = 0; b_in_mode = 0;
        tick();
        chk("b_drain", 32'(b_out_valid), 0);

        // ---------------- asynchronous reset with two beats buffered ----------------
        b_out_ready = 0; b_in_valid = 1; b_in_bin = 4'd1;
        tick();
        b_in_bin = 4'd2;
        tick();
        b_in_valid = 0;
        chk("pre_rst_valid", 32'(b_out_valid), 1);
        chk("pre_rst_ready", 32'(b_in_ready),  0);
        chk("pre_rst_cnt",   32'(b_err_cnt),   1);
        #3;
        rst_n = 0;
        #1;
        chk("arst_valid", 32'(b_out_valid), 0);
        chk("arst_cnt",   32'(b_err_cnt),   0);
        chk("arst_code",  32'(b_out_code),  0);
        chk("arst_err",   32'(b_out_err),   0);
        @(posedge clk);
        #1;
        rst_n = 1;
        b_out_ready = 1;
        tick();
        chk("rel_ready", 32'(b_in_ready),  1);
        chk("rel_idle",  32'(b_out_valid), 0);
        b_in_valid = 1; b_in_bin = 4'd2;
        tick();
        chk("rel_code",  32'(b_out_code),  32'h004);
        chk("rel_valid", 32'(b_out_valid), 1);
        b_in_valid = 0;
        tick();
        chk("rel_no_stale", 32'(b_out_valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
